data_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter that shares the data memory bus between the Gumnut core's data port (master 0) and an auxiliary master (master 1, e.g. DMA or debug loader).
- Sits between the core/aux data ports and data_mem, using the same cyc/stb/we/ack handshake.
- Round-robin grant, held for the whole cycle (cyc), with a per-access ack timeout that returns an error pulse instead of hanging the requester.

---
 rtl/data_bus_arbiter_if.sv | 58 +++++
 rtl/data_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Signal bundle between the arbiter and its surroundings (two masters plus data_mem).
// The slave modport is the arbiter's view. The master modport is the view of the
// system around it: the cores drive the m* requests and data_mem drives s_dat_i/s_ack_i.
interface data_bus_arbiter_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
);
   // Master 0 (Gumnut data port)
   logic          m0_cyc_i;
   logic          m0_stb_i;
   logic          m0_we_i;
   logic [AW-1:0] m0_adr_i;
   logic [DW-1:0] m0_dat_i;
   logic [DW-1:0] m0_dat_o;
   logic          m0_ack_o;
   logic          m0_err_o;

   // Master 1 (auxiliary: DMA / debug loader)
   logic          m1_cyc_i;
   logic          m1_stb_i;
   logic          m1_we_i;
   logic [AW-1:0] m1_adr_i;
   logic [DW-1:0] m1_dat_i;
   logic [DW-1:0] m1_dat_o;
   logic          m1_ack_o;
   logic          m1_err_o;

   // Shared slave bus towards data_mem
   logic          s_cyc_o;
   logic          s_stb_o;
   logic          s_we_o;
   logic [AW-1:0] s_adr_o;
   logic [DW-1:0] s_dat_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;

   logic [1:0]    grant_o;

   modport slave (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      output m0_dat_o, m0_ack_o, m0_err_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
      output m1_dat_o, m1_ack_o, m1_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i,
      output grant_o
   );

   modport master (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
      input  m0_dat_o, m0_ack_o, m0_err_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
      input  m1_dat_o, m1_ack_o, m1_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i,
      input  grant_o
   );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the data memory bus. The grant is held for a
// whole cyc, and each access that gets no ack within TIMEOUT strobe cycles is
// answered with a one-cycle error pulse instead of hanging the requester.
module data_bus_arbiter #(
   parameter int unsigned AW      = 8,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input logic               clk_i,
   input logic               rst_i,
   data_bus_arbiter_if.slave bus
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

   state_e        state_q, state_d;
   logic          last_owner_q, last_owner_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          own_cyc;
   logic          own_stb;
   logic          own_we;
   logic [AW-1:0] own_adr;
   logic [DW-1:0] own_dat;
   logic          in_gnt;
   logic          err_now;
   logic          s_stb;

   // Select the current owner's request signals; zeros when nobody owns the bus.
   always_comb begin
      own_cyc = 1'b0;
      own_stb = 1'b0;
      own_we  = 1'b0;
      own_adr = '0;
      own_dat = '0;
      in_gnt  = 1'b0;
      case (state_q)
         StGnt0: begin
            own_cyc = bus.m0_cyc_i;
            own_stb = bus.m0_stb_i;
            own_we  = bus.m0_we_i;
            own_adr = bus.m0_adr_i;
            own_dat = bus.m0_dat_i;
            in_gnt  = 1'b1;
         end
         StGnt1: begin
            own_cyc = bus.m1_cyc_i;
            own_stb = bus.m1_stb_i;
            own_we  = bus.m1_we_i;
            own_adr = bus.m1_adr_i;
            own_dat = bus.m1_dat_i;
            in_gnt  = 1'b1;
         end
         default: ;
      endcase
   end

   // Timeout detection; an ack arriving on the limit cycle wins over the error.
   always_comb begin
      err_now = in_gnt && (cnt_q == CW'(TIMEOUT)) && !bus.s_ack_i;
      s_stb   = own_stb && !err_now;
   end

   // Drive the slave bus and route ack/err/read data back to the owner only.
   always_comb begin
      bus.s_cyc_o  = own_cyc;
      bus.s_stb_o  = s_stb;
      bus.s_we_o   = own_we;
      bus.s_adr_o  = own_adr;
      bus.s_dat_o  = own_dat;
      bus.m0_ack_o = 1'b0;
      bus.m0_err_o = 1'b0;
      bus.m0_dat_o = '0;
      bus.m1_ack_o = 1'b0;
      bus.m1_err_o = 1'b0;
      bus.m1_dat_o = '0;
      bus.grant_o  = 2'b00;
      if (state_q == StGnt0) begin
         bus.m0_ack_o = bus.s_ack_i && s_stb;
         bus.m0_err_o = err_now;
         bus.m0_dat_o = bus.s_dat_i;
         bus.grant_o  = 2'b01;
      end else if (state_q == StGnt1) begin
         bus.m1_ack_o = bus.s_ack_i && s_stb;
         bus.m1_err_o = err_now;
         bus.m1_dat_o = bus.s_dat_i;
         bus.grant_o  = 2'b10;
      end
   end

   // Arbitration: round-robin on ties, hold while the owner keeps cyc, hand off directly.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         StIdle: begin
            if (bus.m0_cyc_i && bus.m1_cyc_i) begin
               state_d = last_owner_q ? StGnt0 : StGnt1;
            end else if (bus.m0_cyc_i) begin
               state_d = StGnt0;
            end else if (bus.m1_cyc_i) begin
               state_d = StGnt1;
            end
         end
         StGnt0: begin
            last_owner_d = 1'b0;
            if (!bus.m0_cyc_i) begin
               state_d = bus.m1_cyc_i ? StGnt1 : StIdle;
            end
         end
         StGnt1: begin
            last_owner_d = 1'b1;
            if (!bus.m1_cyc_i) begin
               state_d = bus.m0_cyc_i ? StGnt0 : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Count strobe cycles still waiting for an ack; any ack, idle strobe or regrant restarts it.
   always_comb begin
      if ((state_d != state_q) || bus.s_ack_i || !s_stb) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // State registers; reset favours master 0 on the first tie.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         last_owner_q <= 1'b1;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios, a bus-ownership model compared
// against every output on each falling clock edge, and hand-computed literal checks.
module tb_data_bus_arbiter;

   localparam int unsigned TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: owner 0 = nobody, 1 = m0, 2 = m1; last = index of last owning master;
   // wait = strobe cycles of the current access that have gone without an ack.
   int mdl_own  = 0;
   int mdl_last = 1;
   int mdl_wait = 0;

   int n_ack0;
   int n_err0;

   data_bus_arbiter_if #(.AW(8), .DW(8)) bus ();

   data_bus_arbiter #(
      .AW      (8),
      .DW      (8),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic req(input int x);
      return (x == 0) ? bus.m0_cyc_i : bus.m1_cyc_i;
   endfunction

   function automatic logic strobe(input int x);
      return (x == 0) ? bus.m0_stb_i : bus.m1_stb_i;
   endfunction

   function automatic logic exp_err();
      return (mdl_own != 0) && (mdl_wait == TIMEOUT) && !bus.s_ack_i;
   endfunction

   function automatic logic exp_stb();
      return (mdl_own != 0) && strobe(mdl_own - 1) && !exp_err();
   endfunction

   function automatic int nxt_owner();
      if (mdl_own == 0) begin
         if (req(0) && req(1)) return (mdl_last == 0) ? 2 : 1;
         if (req(0)) return 1;
         if (req(1)) return 2;
         return 0;
      end
      if (req(mdl_own - 1)) return mdl_own;
      if (req(2 - mdl_own)) return 3 - mdl_own;
      return 0;
   endfunction

   function automatic int nxt_wait();
      if ((nxt_owner() != mdl_own) || bus.s_ack_i || !exp_stb()) return 0;
      return mdl_wait + 1;
   endfunction

   // Model update
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_own  <= 0;
         mdl_last <= 1;
         mdl_wait <= 0;
      end else begin
         mdl_own  <= nxt_owner();
         mdl_wait <= nxt_wait();
         if (mdl_own != 0) mdl_last <= mdl_own - 1;
      end
   end

   task automatic compare_all();
      logic       e_cyc, e_stb, e_we, e_ack0, e_ack1, e_err0, e_err1;
      logic [7:0] e_adr, e_wdat, e_dat0, e_dat1;
      logic [1:0] e_gnt;
      e_cyc  = 1'b0;
      e_we   = 1'b0;
      e_ack0 = 1'b0;
      e_ack1 = 1'b0;
      e_err0 = 1'b0;
      e_err1 = 1'b0;
      e_adr  = 8'h00;
      e_wdat = 8'h00;
      e_dat0 = 8'h00;
      e_dat1 = 8'h00;
      e_gnt  = 2'b00;
      e_stb  = exp_stb();
      if (mdl_own == 1) begin
         e_cyc  = bus.m0_cyc_i;
         e_we   = bus.m0_we_i;
         e_adr  = bus.m0_adr_i;
         e_wdat = bus.m0_dat_i;
         e_dat0 = bus.s_dat_i;
         e_ack0 = bus.s_ack_i && e_stb;
         e_err0 = exp_err();
         e_gnt  = 2'b01;
      end else if (mdl_own == 2) begin
         e_cyc  = bus.m1_cyc_i;
         e_we   = bus.m1_we_i;
         e_adr  = bus.m1_adr_i;
         e_wdat = bus.m1_dat_i;
         e_dat1 = bus.s_dat_i;
         e_ack1 = bus.s_ack_i && e_stb;
         e_err1 = exp_err();
         e_gnt  = 2'b10;
      end
      cmp("s_cyc", 8'(bus.s_cyc_o), 8'(e_cyc));
      cmp("s_stb", 8'(bus.s_stb_o), 8'(e_stb));
      cmp("s_we", 8'(bus.s_we_o), 8'(e_we));
      cmp("s_adr", bus.s_adr_o, e_adr);
      cmp("s_dat", bus.s_dat_o, e_wdat);
      cmp("m0_ack", 8'(bus.m0_ack_o), 8'(e_ack0));
      cmp("m1_ack", 8'(bus.m1_ack_o), 8'(e_ack1));
      cmp("m0_err", 8'(bus.m0_err_o), 8'(e_err0));
      cmp("m1_err", 8'(bus.m1_err_o), 8'(e_err1));
      cmp("m0_dat", bus.m0_dat_o, e_dat0);
      cmp("m1_dat", bus.m1_dat_o, e_dat1);
      cmp("grant", 8'(bus.grant_o), 8'(e_gnt));
   endtask

   always @(negedge clk) compare_all();

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input int x, input logic c, input logic s, input logic w,
                        input logic [7:0] a, input logic [7:0] d);
      if (x == 0) begin
         bus.m0_cyc_i = c;
         bus.m0_stb_i = s;
         bus.m0_we_i  = w;
         bus.m0_adr_i = a;
         bus.m0_dat_i = d;
      end else begin
         bus.m1_cyc_i = c;
         bus.m1_stb_i = s;
         bus.m1_we_i  = w;
         bus.m1_adr_i = a;
         bus.m1_dat_i = d;
      end
   endtask

   task automatic sl(input logic ack, input logic [7:0] dat);
      bus.s_ack_i = ack;
      bus.s_dat_i = dat;
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sl(1'b0, 8'h00);
      mid();
      cmp("lit_rst_grant", 8'(bus.grant_o), 8'h00);
      cmp("lit_rst_scyc", 8'(bus.s_cyc_o), 8'h00);
      nx();
      rst = 1'b0;

      // Tie after reset: m0 wins, one cycle of arbitration.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
      drive(1, 1'b1, 1'b1, 1'b1, 8'h20, 8'h3C);
      mid();
      cmp("lit_arb_cycle_grant", 8'(bus.grant_o), 8'h00);
      nx();
      mid();
      cmp("lit_tie_grant", 8'(bus.grant_o), 8'h01);
      cmp("lit_tie_sadr", bus.s_adr_o, 8'h10);
      nx();
      sl(1'b1, 8'hA5);
      mid();
      cmp("lit_m0_ack", 8'(bus.m0_ack_o), 8'h01);
      cmp("lit_m0_dat", bus.m0_dat_o, 8'hA5);
      cmp("lit_m1_noack", 8'(bus.m1_ack_o), 8'h00);
      nx();
      sl(1'b0, 8'h00);
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      mid();
      cmp("lit_fall_scyc", 8'(bus.s_cyc_o), 8'h00);
      nx();
      mid();
      cmp("lit_handoff_grant", 8'(bus.grant_o), 8'h02);
      cmp("lit_m1_swe", 8'(bus.s_we_o), 8'h01);
      cmp("lit_m1_sadr", bus.s_adr_o, 8'h20);
      cmp("lit_m1_sdat", bus.s_dat_o, 8'h3C);
      nx();
      sl(1'b1, 8'h5A);
      mid();
      cmp("lit_m1_ack", 8'(bus.m1_ack_o), 8'h01);
      nx();
      sl(1'b0, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      nx();
      // Idle now; m1 owned last, so a tie goes to m0.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h11, 8'h00);
      drive(1, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
      nx();
      mid();
      cmp("lit_rr_m0", 8'(bus.grant_o), 8'h01);
      nx();
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      nx();
      // Idle; m0 owned last, so a tie goes to m1.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h00);
      drive(1, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00);
      nx();
      mid();
      cmp("lit_rr_m1", 8'(bus.grant_o), 8'h02);
      nx();
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      nx();

      // Hold under contention: four back-to-back strobes all go to m0.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00);
      nx();
      drive(1, 1'b1, 1'b1, 1'b0, 8'h50, 8'h00);
      n_ack0 = 0;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 8'h40 + 8'(i), 8'h00);
         sl(1'b1, 8'h80 + 8'(i));
         mid();
         if (bus.m0_ack_o === 1'b1) n_ack0++;
         cmp("lit_hold_grant", 8'(bus.grant_o), 8'h01);
         nx();
      end
      cmp("lit_hold_acks", 8'(n_ack0), 8'h04);
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sl(1'b0, 8'h00);
      mid();
      cmp("lit_hold_fall", 8'(bus.grant_o), 8'h01);
      nx();
      mid();
      cmp("lit_hold_m1", 8'(bus.grant_o), 8'h02);
      nx();
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      nx();

      // Timeout: no ack, error 16 cycles after the request, then a retry completes.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h60, 8'h00);
      n_err0 = 0;
      for (int k = 0; k < 18; k++) begin
         mid();
         if (bus.m0_err_o === 1'b1) n_err0++;
         if (k == 16) begin
            cmp("lit_to_err", 8'(bus.m0_err_o), 8'h01);
            cmp("lit_to_stb_low", 8'(bus.s_stb_o), 8'h00);
         end
         nx();
      end
      cmp("lit_to_err_once", 8'(n_err0), 8'h01);
      sl(1'b1, 8'hC3);
      mid();
      cmp("lit_retry_ack", 8'(bus.m0_ack_o), 8'h01);
      cmp("lit_retry_dat", bus.m0_dat_o, 8'hC3);
      nx();
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sl(1'b0, 8'h00);
      nx();

      // Ack on the limit cycle: ack only, no error.
      drive(0, 1'b1, 1'b1, 1'b0, 8'h70, 8'h00);
      n_err0 = 0;
      for (int k = 0; k < 17; k++) begin
         sl(k == 16, 8'h99);
         mid();
         if (bus.m0_err_o === 1'b1) n_err0++;
         if (k == 16) cmp("lit_limit_ack", 8'(bus.m0_ack_o), 8'h01);
         nx();
      end
      cmp("lit_limit_no_err", 8'(n_err0), 8'h00);
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      sl(1'b0, 8'h00);
      nx();
      nx();

      // Async reset in the middle of an m1 strobe.
      drive(1, 1'b1, 1'b1, 1'b1, 8'h88, 8'h77);
      nx();
      mid();
      cmp("lit_pre_rst_grant", 8'(bus.grant_o), 8'h02);
      #2;
      rst = 1'b1;
      sl(1'b1, 8'hEE);
      drive(0, 1'b1, 1'b1, 1'b0, 8'h90, 8'h00);
      #1;
      cmp("lit_async_grant", 8'(bus.grant_o), 8'h00);
      cmp("lit_async_scyc", 8'(bus.s_cyc_o), 8'h00);
      cmp("lit_async_sstb", 8'(bus.s_stb_o), 8'h00);
      cmp("lit_async_ack", 8'(bus.m1_ack_o), 8'h00);
      nx();
      rst = 1'b0;
      mid();
      cmp("lit_release_noack", 8'(bus.m1_ack_o), 8'h00);
      nx();
      sl(1'b0, 8'h00);
      mid();
      cmp("lit_post_rst_tie", 8'(bus.grant_o), 8'h01);
      nx();
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      nx();
      nx();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
